char_dir_stepper: RTL and testbench

CHAR_DIR_STEPPER -- requirements
Module: char_dir_stepper

---
 rtl/char_dir_stepper_pkg.sv | 31 +++
 rtl/char_dir_stepper_if.sv | 35 +++
 rtl/char_dir_decode.sv | 17 +
 rtl/char_dir_stepper.sv | 135 +++++++++++++
 tb/tb_char_dir_stepper.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/char_dir_stepper_pkg.sv
// -----------------------------------------------------------------------------
// char_dir_stepper_pkg
// Shared definitions for the character direction stepper and its neighbours.
//   COORD_W              : width of a grid coordinate
//   coord_t              : grid coordinate type
//   DIR_PX/PY/NX/NY      : 2-bit direction codes (+x, +y, -x, -y)
//   state_t              : stepper FSM states
//   clamp_coord()        : limit a coordinate to a maximum value
// -----------------------------------------------------------------------------
package char_dir_stepper_pkg;

    localparam int COORD_W = 5;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [1:0] DIR_PX = 2'd0;
    localparam logic [1:0] DIR_PY = 2'd1;
    localparam logic [1:0] DIR_NX = 2'd2;
    localparam logic [1:0] DIR_NY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    function automatic coord_t clamp_coord(input coord_t value, input coord_t max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/char_dir_stepper_if.sv
// -----------------------------------------------------------------------------
// char_dir_stepper_if
// Bundles the stepper's control inputs and status outputs.
//   master : drives tick, dir_valid, charDir, load, load_x, load_y;
//            observes dir_ready, pos_x, pos_y, axis, dir, moving, blocked
//   slave  : the stepper side (mirror of master)
// -----------------------------------------------------------------------------
interface char_dir_stepper_if;
    import char_dir_stepper_pkg::*;

    logic       tick;
    logic       dir_valid;
    logic [1:0] charDir;
    logic       dir_ready;
    logic       load;
    coord_t     load_x;
    coord_t     load_y;
    coord_t     pos_x;
    coord_t     pos_y;
    logic       axis;
    logic       dir;
    logic       moving;
    logic       blocked;

    modport master (
        output tick, dir_valid, charDir, load, load_x, load_y,
        input  dir_ready, pos_x, pos_y, axis, dir, moving, blocked
    );

    modport slave (
        input  tick, dir_valid, charDir, load, load_x, load_y,
        output dir_ready, pos_x, pos_y, axis, dir, moving, blocked
    );

endinterface

// File: rtl/char_dir_decode.sv
// -----------------------------------------------------------------------------
// char_dir_decode
// Combinational decode of a 2-bit direction code into axis and sign.
//   code : direction code (0=+x, 1=+y, 2=-x, 3=-y)
//   axis : 0 = x axis, 1 = y axis
//   dir  : 1 = positive, 0 = negative
// -----------------------------------------------------------------------------
module char_dir_decode (
    input  logic [1:0] code,
    output logic       axis,
    output logic       dir
);

    assign axis = code[0];
    assign dir  = ~code[1];

endmodule

// File: rtl/char_dir_stepper.sv
// -----------------------------------------------------------------------------
// char_dir_stepper
// Moves a character one grid cell every STEP_DIV game ticks in the latched
// direction, refusing steps that would leave the grid.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of char_dir_stepper_if
//                (tick, direction handshake, position load, position/status)
// Parameters: GRID_W/GRID_H grid size, STEP_DIV ticks per step,
//             START_X/START_Y reset position.
// -----------------------------------------------------------------------------
module char_dir_stepper
    import char_dir_stepper_pkg::*;
#(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 12,
    parameter int STEP_DIV = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    char_dir_stepper_if.slave  bus
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam coord_t X_MAX   = coord_t'(GRID_W - 1);
    localparam coord_t Y_MAX   = coord_t'(GRID_H - 1);
    localparam coord_t X_START = coord_t'(START_X);
    localparam coord_t Y_START = coord_t'(START_Y);

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [DIV_W-1:0] div_q, div_d;
    coord_t           pos_x_q, pos_x_d;
    coord_t           pos_y_q, pos_y_d;
    logic             blocked_q, blocked_d;

    logic cur_axis;
    logic cur_dir;
    logic commit;
    logic xfer;
    logic at_edge;

    char_dir_decode u_decode (
        .code (code_q),
        .axis (cur_axis),
        .dir  (cur_dir)
    );

    // A step commits on the last divider tick; the handshake is held off
    // in that cycle so a new direction never races the step being taken.
    assign commit = (state_q == ST_RUN) && bus.tick && (div_q == DIV_LAST);
    assign xfer   = bus.dir_valid && !commit;

    // True when the next step in the latched direction would leave the grid.
    always_comb begin
        at_edge = 1'b0;
        case ({cur_axis, cur_dir})
            2'b01:   at_edge = (pos_x_q == X_MAX);
            2'b00:   at_edge = (pos_x_q == '0);
            2'b11:   at_edge = (pos_y_q == Y_MAX);
            2'b10:   at_edge = (pos_y_q == '0);
            default: at_edge = 1'b0;
        endcase
    end

    // Next-state logic. Priority: tick/step, then load (overrides the step),
    // then direction transfer (overrides the state so load+transfer enters RUN).
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        div_d     = div_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        blocked_d = 1'b0;

        if ((state_q == ST_RUN) && bus.tick) begin
            if (commit) begin
                div_d = '0;
                if (at_edge) begin
                    blocked_d = 1'b1;
                    state_d   = ST_BLOCKED;
                end else if (!cur_axis) begin
                    pos_x_d = cur_dir ? (pos_x_q + coord_t'(1)) : (pos_x_q - coord_t'(1));
                end else begin
                    pos_y_d = cur_dir ? (pos_y_q + coord_t'(1)) : (pos_y_q - coord_t'(1));
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (bus.load) begin
            pos_x_d   = clamp_coord(bus.load_x, X_MAX);
            pos_y_d   = clamp_coord(bus.load_y, Y_MAX);
            div_d     = '0;
            blocked_d = 1'b0;
            state_d   = state_q;
        end

        if (xfer) begin
            code_d  = bus.charDir;
            div_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= DIR_PX;
            div_q     <= '0;
            pos_x_q   <= X_START;
            pos_y_q   <= Y_START;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            div_q     <= div_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            blocked_q <= blocked_d;
        end
    end

    assign bus.dir_ready = !commit;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.axis      = cur_axis;
    assign bus.dir       = cur_dir;
    assign bus.moving    = (state_q == ST_RUN);
    assign bus.blocked   = blocked_q;

endmodule

// File: tb/tb_char_dir_stepper.sv
// -----------------------------------------------------------------------------
// tb_char_dir_stepper
// Self-checking bench for char_dir_stepper (GRID 16x12, STEP_DIV 4, start 0,0).
// -----------------------------------------------------------------------------
module tb_char_dir_stepper;
    import char_dir_stepper_pkg::*;

    typedef struct {
        logic       tick;
        logic       dv;
        logic [1:0] code;
        logic       ld;
        logic [4:0] lx;
        logic [4:0] ly;
        logic       rdy;
        logic [4:0] px;
        logic [4:0] py;
        logic       mv;
        logic       blk;
        logic       ax;
        logic       dr;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] px;
        logic [4:0] py;
        logic       mv;
        logic       blk;
        logic       ax;
        logic       dr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    char_dir_stepper_if bus();

    char_dir_stepper #(
        .GRID_W   (16),
        .GRID_H   (12),
        .STEP_DIV (4),
        .START_X  (0),
        .START_Y  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(input int t, input int dv, input int code, input int ld,
                                 input int lx, input int ly, input int rdy, input int px,
                                 input int py, input int mv, input int blk, input int ax,
                                 input int dr);
        vec_t v;
        v.tick = t[0];   v.dv = dv[0];   v.code = code[1:0]; v.ld = ld[0];
        v.lx   = lx[4:0]; v.ly = ly[4:0]; v.rdy = rdy[0];
        v.px   = px[4:0]; v.py = py[4:0]; v.mv = mv[0]; v.blk = blk[0];
        v.ax   = ax[0];   v.dr = dr[0];
        return v;
    endfunction

    task automatic checkValue(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, check the combinational ready, queue the
    // outputs expected after the coming edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        bus.tick      = v.tick;
        bus.dir_valid = v.dv;
        bus.charDir   = v.code;
        bus.load      = v.ld;
        bus.load_x    = v.lx;
        bus.load_y    = v.ly;
        #1;
        checkValue($sformatf("v%0d dir_ready", idx), int'(bus.dir_ready), int'(v.rdy));
        e.idx = idx; e.px = v.px; e.py = v.py; e.mv = v.mv;
        e.blk = v.blk; e.ax = v.ax; e.dr = v.dr;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkValue("scoreboard empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            checkValue($sformatf("v%0d pos_x", e.idx),   int'(bus.pos_x),   int'(e.px));
            checkValue($sformatf("v%0d pos_y", e.idx),   int'(bus.pos_y),   int'(e.py));
            checkValue($sformatf("v%0d moving", e.idx),  int'(bus.moving),  int'(e.mv));
            checkValue($sformatf("v%0d blocked", e.idx), int'(bus.blocked), int'(e.blk));
            checkValue($sformatf("v%0d axis", e.idx),    int'(bus.axis),    int'(e.ax));
            checkValue($sformatf("v%0d dir", e.idx),     int'(bus.dir),     int'(e.dr));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, " pos_x"},     int'(bus.pos_x),     0);
        checkValue({tag, " pos_y"},     int'(bus.pos_y),     0);
        checkValue({tag, " moving"},    int'(bus.moving),    0);
        checkValue({tag, " blocked"},   int'(bus.blocked),   0);
        checkValue({tag, " axis"},      int'(bus.axis),      0);
        checkValue({tag, " dir"},       int'(bus.dir),       1);
        checkValue({tag, " dir_ready"}, int'(bus.dir_ready), 1);
    endtask

    initial begin
        int seen;

        // Columns: tick dv code ld lx ly | rdy(pre-edge) px py mv blk ax dr
        tbl.push_back(mkv(0,1,0,0, 0, 0, 1,  0, 0,1,0,0,1));  // transfer +x
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0,  1, 0,1,0,0,1));  // 4th tick steps
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  1, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  1, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  1, 0,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0,  2, 0,1,0,0,1));  // 8th tick steps
        tbl.push_back(mkv(0,0,0,0, 0, 0, 1,  2, 0,1,0,0,1));
        tbl.push_back(mkv(0,0,0,1,15, 5, 1, 15, 5,1,0,0,1));  // load right edge
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0, 15, 5,0,1,0,1));  // refused at x max
        tbl.push_back(mkv(0,0,0,0, 0, 0, 1, 15, 5,0,0,0,1));  // single pulse
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,0,0,0,1));  // tick ignored
        tbl.push_back(mkv(0,1,2,0, 0, 0, 1, 15, 5,1,0,0,0));  // reversal -x
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1, 15, 5,1,0,0,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0, 14, 5,1,0,0,0));
        tbl.push_back(mkv(0,0,0,1,31,20, 1, 15,11,1,0,0,0));  // clamped load
        tbl.push_back(mkv(0,1,3,1, 0, 0, 1,  0, 0,1,0,1,0));  // load + transfer -y
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,0));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0,  0, 0,0,1,1,0));  // refused at y 0
        tbl.push_back(mkv(0,1,1,0, 0, 0, 1,  0, 0,1,0,1,1));  // +y
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 0,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0,  0, 1,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 1,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 1,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  0, 1,1,0,1,1));
        tbl.push_back(mkv(1,0,0,1, 3, 3, 0,  3, 3,1,0,1,1));  // load beats step
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 3,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 3,1,0,1,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 3,1,0,1,1));
        tbl.push_back(mkv(1,1,0,0, 0, 0, 0,  3, 4,1,0,1,1));  // valid held, not taken
        tbl.push_back(mkv(0,1,0,0, 0, 0, 1,  3, 4,1,0,0,1));  // taken next cycle
        tbl.push_back(mkv(0,0,0,0, 0, 0, 1,  3, 4,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 4,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 4,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 1,  3, 4,1,0,0,1));
        tbl.push_back(mkv(1,0,0,0, 0, 0, 0,  4, 4,1,0,0,1));

        rst_n         = 1'b0;
        bus.tick      = 1'b0;
        bus.dir_valid = 1'b0;
        bus.charDir   = 2'd0;
        bus.load      = 1'b0;
        bus.load_x    = '0;
        bus.load_y    = '0;
        #2;
        checkResetOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
            checkOutput();
        end

        // Asynchronous reset between edges while running at (4,4).
        @(negedge clk);
        bus.tick      = 1'b0;
        bus.dir_valid = 1'b0;
        bus.load      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("async");

        // Ticks straight after reset release must not move an idle stepper.
        @(negedge clk);
        rst_n    = 1'b1;
        bus.tick = 1'b1;
        @(posedge clk);
        #1;
        checkValue("idle tick pos_x", int'(bus.pos_x), 0);
        checkValue("idle tick moving", int'(bus.moving), 0);

        // -x from x=0: blocked must appear on the 4th tick, bounded wait.
        @(negedge clk);
        bus.tick      = 1'b0;
        bus.dir_valid = 1'b1;
        bus.charDir   = DIR_NX;
        @(negedge clk);
        bus.dir_valid = 1'b0;
        bus.tick      = 1'b1;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.blocked) begin
                seen = c;
                break;
            end
        end
        checkValue("left edge blocked tick", seen, 4);
        checkValue("left edge pos_x", int'(bus.pos_x), 0);
        checkValue("left edge moving", int'(bus.moving), 0);
        bus.tick = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
